// File: rtl/wb_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module : wb_bus_pkg
// Shared types and field widths for the wb_shared_bus interconnect.
// Rev    : 1.0
// ============================================================================
package wb_bus_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  // Slave index lives in the top c_SIDX_W address bits.
  localparam int c_SIDX_W = 4;
  localparam int c_CNT_W  = 16;

endpackage
`default_nettype wire

// File: rtl/wb_shared_bus_if.sv
`default_nettype none
// ============================================================================
// Module : wb_shared_bus_if
// Master-side and slave-side Wishbone bundles of the shared bus.
// Rev    : 1.0
// ============================================================================
interface wb_shared_bus_if #(
  parameter int NUM_M = 2,
  parameter int NUM_S = 4,
  parameter int DW    = 32,
  parameter int AW    = 32
);

  logic [NUM_M-1:0]        m_cyc_i;
  logic [NUM_M-1:0]        m_stb_i;
  logic [NUM_M-1:0]        m_we_i;
  logic [NUM_M*AW-1:0]     m_addr_i;
  logic [NUM_M*DW-1:0]     m_data_i;
  logic [NUM_M*DW/8-1:0]   m_sel_i;
  logic [NUM_M*DW-1:0]     m_data_o;
  logic [NUM_M-1:0]        m_ack_o;
  logic [NUM_M-1:0]        m_err_o;

  logic [NUM_S-1:0]        s_cyc_o;
  logic [NUM_S-1:0]        s_stb_o;
  logic [NUM_S-1:0]        s_we_o;
  logic [NUM_S*AW-1:0]     s_addr_o;
  logic [NUM_S*DW-1:0]     s_data_o;
  logic [NUM_S*DW/8-1:0]   s_sel_o;
  logic [NUM_S*DW-1:0]     s_data_i;
  logic [NUM_S-1:0]        s_ack_i;
  logic [NUM_S-1:0]        s_err_i;

  // master: the interconnect, which masters every slave port.
  modport master (
    input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, m_sel_i,
    output m_data_o, m_ack_o, m_err_o,
    output s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o, s_sel_o,
    input  s_data_i, s_ack_i, s_err_i
  );

  // slave: the attached masters/slaves seen from the outside.
  modport slave (
    output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, m_sel_i,
    input  m_data_o, m_ack_o, m_err_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o, s_sel_o,
    output s_data_i, s_ack_i, s_err_i
  );

endinterface
`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : wb_rr_arbiter
// Combinational round-robin: first request at or after i_ptr wins (one-hot).
// Rev    : 1.0
// ============================================================================
module wb_rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant
);

  logic w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!w_found && i_req[j] && (j == (int'(i_ptr) + i) % N)) begin
          o_grant[j] = 1'b1;
          w_found    = 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_shared_bus.sv
`default_nettype none
// ============================================================================
// Module : wb_shared_bus
// Round-robin shared Wishbone bus, NUM_M masters to NUM_S address-decoded
// slaves. Optional watchdog error: define WB_BUS_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
module wb_shared_bus
  import wb_bus_pkg::*;
#(
  parameter int NUM_M   = 2,
  parameter int NUM_S   = 4,
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  wb_shared_bus_if.master bus
);

  localparam int c_SW = DW / 8;
  localparam int c_PW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  if (NUM_M < 1 || NUM_M > 8 || NUM_S < 1 || NUM_S > 16 || AW < c_SIDX_W ||
      (DW % 8) != 0 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_params
    $error("wb_shared_bus: parameter out of supported range");
  end

  state_t                r_state;
  logic [c_PW-1:0]       r_owner;
  logic [c_PW-1:0]       r_ptr;
  logic                  r_miss_err;

  logic [NUM_M-1:0]      w_grant;
  logic [c_PW-1:0]       w_grant_idx;
  logic                  w_own_cyc;
  logic                  w_own_stb_raw;
  logic                  w_own_we;
  logic [AW-1:0]         w_own_addr;
  logic [DW-1:0]         w_own_data;
  logic [c_SW-1:0]       w_own_sel;
  logic [c_SIDX_W-1:0]   w_sidx;
  logic                  w_hit;
  logic                  w_active;
  logic                  w_own_stb;
  logic                  w_slv_ack;
  logic                  w_slv_err;
  logic [DW-1:0]         w_slv_data;
  logic                  w_to;

  wb_rr_arbiter #(
    .N  (NUM_M),
    .PW (c_PW)
  ) u_arb (
    .i_req   (bus.m_cyc_i),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  // Owner-side mux: everything downstream works on the owner's signals only.
  always_comb begin
    w_grant_idx   = '0;
    w_own_cyc     = 1'b0;
    w_own_stb_raw = 1'b0;
    w_own_we      = 1'b0;
    w_own_addr    = '0;
    w_own_data    = '0;
    w_own_sel     = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (w_grant[k]) w_grant_idx = c_PW'(k);
      if (r_owner == c_PW'(k)) begin
        w_own_cyc     = bus.m_cyc_i[k];
        w_own_stb_raw = bus.m_stb_i[k];
        w_own_we      = bus.m_we_i[k];
        w_own_addr    = bus.m_addr_i[k*AW +: AW];
        w_own_data    = bus.m_data_i[k*DW +: DW];
        w_own_sel     = bus.m_sel_i[k*c_SW +: c_SW];
      end
    end
  end

  assign w_sidx    = w_own_addr[AW-1 -: c_SIDX_W];
  assign w_hit     = (32'(w_sidx) < NUM_S);
  assign w_active  = !rst && (r_state == ST_OWNED) && w_own_cyc;
  assign w_own_stb = w_active && w_own_stb_raw;

  always_comb begin
    w_slv_ack  = 1'b0;
    w_slv_err  = 1'b0;
    w_slv_data = '0;
    for (int j = 0; j < NUM_S; j++) begin
      if (w_sidx == c_SIDX_W'(j)) begin
        w_slv_ack  = bus.s_ack_i[j];
        w_slv_err  = bus.s_err_i[j];
        w_slv_data = bus.s_data_i[j*DW +: DW];
      end
    end
  end

`ifdef WB_BUS_TIMEOUT_EN
  // Watchdog never depends on the slave's ack, so s_stb_o -> ack -> s_stb_o
  // cannot form a loop through an external slave.
  logic [c_CNT_W-1:0] r_wd_cnt;

  assign w_to = w_own_stb && w_hit && (r_wd_cnt == c_CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt <= '0;
    end else if (!w_own_stb || !w_hit || w_slv_ack || w_slv_err || w_to) begin
      r_wd_cnt <= '0;
    end else begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end
`else
  assign w_to = 1'b0;
`endif

  always_comb begin
    bus.s_cyc_o  = '0;
    bus.s_stb_o  = '0;
    bus.s_we_o   = '0;
    bus.s_addr_o = '0;
    bus.s_data_o = '0;
    bus.s_sel_o  = '0;
    bus.m_ack_o  = '0;
    bus.m_err_o  = '0;
    bus.m_data_o = '0;
    for (int j = 0; j < NUM_S; j++) begin
      if (w_active && (w_sidx == c_SIDX_W'(j))) begin
        bus.s_cyc_o[j]                = 1'b1;
        bus.s_stb_o[j]                = w_own_stb && !w_to;
        bus.s_we_o[j]                 = w_own_we;
        bus.s_addr_o[j*AW +: AW]      = w_own_addr;
        bus.s_data_o[j*DW +: DW]      = w_own_data;
        bus.s_sel_o[j*c_SW +: c_SW]   = w_own_sel;
      end
    end
    for (int k = 0; k < NUM_M; k++) begin
      if (w_active && (r_owner == c_PW'(k))) begin
        bus.m_ack_o[k]          = w_hit && w_own_stb && w_slv_ack && !w_to;
        bus.m_err_o[k]          = (w_hit && w_own_stb && w_slv_err) || w_to || r_miss_err;
        bus.m_data_o[k*DW +: DW] = w_hit ? w_slv_data : '0;
      end
    end
  end

  // Ownership ends on the edge that sees the owner's cyc low; the next grant
  // always comes out of IDLE, which yields the one-cycle gap between owners.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_miss_err <= 1'b0;
    end else begin
      r_miss_err <= w_own_stb && !w_hit && !r_miss_err;
      case (r_state)
        ST_IDLE: begin
          if (|bus.m_cyc_i) begin
            r_state <= ST_OWNED;
            r_owner <= w_grant_idx;
          end
        end
        ST_OWNED: begin
          if (!w_own_cyc) begin
            r_state <= ST_IDLE;
            r_ptr   <= (r_owner == c_PW'(NUM_M - 1)) ? '0 : r_owner + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
